bfs_frontier: RTL

BFS_FRONTIER -- requirements
Module: bfs_frontier

---
 rtl/bfs_pkg.sv | 21 ++
 rtl/bfs_frontier_if.sv | 50 +++++
 rtl/bfs_frontier_fifo.sv | 64 ++++++
 rtl/bfs_frontier.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/bfs_pkg.sv
// ============================================================================
// Module   : bfs_pkg
// Brief    : Shared vertex type and traversal FSM encoding for bfs_frontier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bfs_pkg;

  typedef logic [31:0] vertex_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bfs_frontier_if.sv
// ============================================================================
// Module   : bfs_frontier_if
// Brief    : Start, neighbour and vertex-issue handshakes of bfs_frontier.
//            Statistics outputs exist only when BFS_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bfs_frontier_if;
  import bfs_pkg::*;

  logic    start_in;
  vertex_t root_in;
  vertex_t nbr_in;
  logic    nbr_valid_in;
  logic    nbr_ready_out;
  logic    row_done_in;
  vertex_t v_id_out;
  logic    v_valid_out;
  logic    v_ready_in;
  logic    busy_out;
  logic    done_out;
`ifdef BFS_STATS_EN
  logic [31:0] visited_cnt_out;
  logic [31:0] drop_oor_cnt_out;

  modport slave (
    input  start_in, root_in, nbr_in, nbr_valid_in, row_done_in, v_ready_in,
    output nbr_ready_out, v_id_out, v_valid_out, busy_out, done_out,
    output visited_cnt_out, drop_oor_cnt_out
  );
  modport master (
    output start_in, root_in, nbr_in, nbr_valid_in, row_done_in, v_ready_in,
    input  nbr_ready_out, v_id_out, v_valid_out, busy_out, done_out,
    input  visited_cnt_out, drop_oor_cnt_out
  );
`else
  modport slave (
    input  start_in, root_in, nbr_in, nbr_valid_in, row_done_in, v_ready_in,
    output nbr_ready_out, v_id_out, v_valid_out, busy_out, done_out
  );
  modport master (
    output start_in, root_in, nbr_in, nbr_valid_in, row_done_in, v_ready_in,
    input  nbr_ready_out, v_id_out, v_valid_out, busy_out, done_out
  );
`endif

endinterface

`default_nettype wire

// File: rtl/bfs_frontier_fifo.sv
// ============================================================================
// Module   : bfs_frontier_fifo
// Brief    : Synchronous FIFO; head word is visible combinationally on o_data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bfs_frontier_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_push,
  input  wire logic [DATA_WIDTH-1:0] i_data,
  input  wire logic                  i_pop,
  output logic      [DATA_WIDTH-1:0] o_data,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]       r_wr_ptr;
  logic [c_aw-1:0]       r_rd_ptr;
  logic [c_cw-1:0]       r_count;
  logic                  w_push;
  logic                  w_pop;

  function automatic logic [c_aw-1:0] next_ptr(input logic [c_aw-1:0] p);
    return (p == c_aw'(DEPTH - 1)) ? '0 : p + c_aw'(1);
  endfunction

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_cw'(DEPTH));
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/bfs_frontier.sv
// ============================================================================
// Module   : bfs_frontier
// Brief    : BFS frontier manager: visited bitmap, frontier queue, issue FSM.
//            Define BFS_STATS_EN to add visited / out-of-range counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bfs_frontier import bfs_pkg::*; #(
  parameter int NUM_V  = 256,
  parameter int QDEPTH = 16
) (
  input wire logic      clk_in,
  input wire logic      rst_in,
  bfs_frontier_if.slave bus
);

  localparam int      c_idx_w = (NUM_V > 1) ? $clog2(NUM_V) : 1;
  localparam vertex_t c_num_v = vertex_t'(NUM_V);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_V-1:0]   r_visited;
  logic               w_fifo_rst;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_push;
  logic               w_pop;
  vertex_t            w_push_data;
  vertex_t            w_head;
  logic               w_start_acc;
  logic               w_nbr_acc;
  logic               w_nbr_new;
  logic               w_root_ok;
  logic               w_nbr_ok;
  logic [c_idx_w-1:0] w_root_idx;
  logic [c_idx_w-1:0] w_nbr_idx;

  assign w_fifo_rst = !rst_in;
  assign w_root_ok  = (bus.root_in < c_num_v);
  assign w_nbr_ok   = (bus.nbr_in < c_num_v);
  assign w_root_idx = bus.root_in[c_idx_w-1:0];
  assign w_nbr_idx  = bus.nbr_in[c_idx_w-1:0];

  bfs_frontier_fifo #(
    .DATA_WIDTH (32),
    .DEPTH      (QDEPTH)
  ) u_queue (
    .clk     (clk_in),
    .rst     (w_fifo_rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_push            = 1'b0;
    w_push_data       = bus.root_in;
    w_pop             = 1'b0;
    w_start_acc       = 1'b0;
    w_nbr_acc         = 1'b0;
    w_nbr_new         = 1'b0;
    bus.nbr_ready_out = 1'b0;
    bus.v_valid_out   = 1'b0;
    bus.v_id_out      = '0;
    bus.busy_out      = 1'b0;
    bus.done_out      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_in) begin
          w_start_acc = 1'b1;
          w_push      = w_root_ok;
          w_state_nxt = w_root_ok ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        bus.busy_out = 1'b1;
        if (w_fifo_empty) begin
          w_state_nxt = ST_DONE;
        end else begin
          bus.v_valid_out = 1'b1;
          bus.v_id_out    = w_head;
          if (bus.v_ready_in) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        bus.busy_out      = 1'b1;
        bus.nbr_ready_out = !w_fifo_full;
        w_nbr_acc         = bus.nbr_valid_in && !w_fifo_full;
        // The bitmap lookup sees last cycle's write, so repeated ids collapse.
        if (w_nbr_acc && w_nbr_ok && !r_visited[w_nbr_idx]) begin
          w_nbr_new   = 1'b1;
          w_push      = 1'b1;
          w_push_data = bus.nbr_in;
        end
        if (bus.row_done_in) w_state_nxt = ST_ISSUE;
      end
      ST_DONE: begin
        bus.done_out = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_visited <= '0;
    end else if (w_start_acc) begin
      r_visited <= '0;
      if (w_root_ok) r_visited[w_root_idx] <= 1'b1;
    end else if (w_nbr_new) begin
      r_visited[w_nbr_idx] <= 1'b1;
    end
  end

`ifdef BFS_STATS_EN
  logic [31:0] r_visited_cnt;
  logic [31:0] r_drop_oor_cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_visited_cnt  <= '0;
      r_drop_oor_cnt <= '0;
    end else if (w_start_acc) begin
      r_visited_cnt  <= w_root_ok ? 32'd1 : 32'd0;
      r_drop_oor_cnt <= '0;
    end else begin
      if (w_nbr_new && (r_visited_cnt != '1))
        r_visited_cnt <= r_visited_cnt + 32'd1;
      if (w_nbr_acc && !w_nbr_ok && (r_drop_oor_cnt != '1))
        r_drop_oor_cnt <= r_drop_oor_cnt + 32'd1;
    end
  end

  assign bus.visited_cnt_out  = r_visited_cnt;
  assign bus.drop_oor_cnt_out = r_drop_oor_cnt;
`endif

endmodule

`default_nettype wire
